regfile_bank: RTL and testbench
===============================

# regfile_bank

Parametrised general-purpose register bank for the multicycle MIPS datapath, generalising the fixed 32×32 bank. Configurable data width, register count and stack-pointer initial value; two combinational read ports, a display read port, a main write port and a prioritised auxiliary write port for syscall/I-O injection into any register. Contents are initialised by a counter-driven sweep after reset or on a soft-clear request, so the array maps onto RAM-style storage with no per-bit reset. Sits between the control FSM/ALU write-back path and the operand latches.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; bank holds 2^ADDR_W registers
- SP_REG, 29, index of the stack pointer register
- SP_INIT, 32'd32764, value loaded into SP_REG by every clear sweep (truncated to DATA_W)

- iCLK  in  1  clock; all state changes on its rising edge
- iCLRn  in  1  reset, asynchronous, active-low
- iSoftClr  in  1  synchronous request to restart the clear sweep
- iReadRegister1, iReadRegister2  in  ADDR_W  read port indices
- oReadData1, oReadData2  out  DATA_W  read port data, combinational
- iRegDispSelect  in  ADDR_W  display port index
- oRegDisp  out  DATA_W  display port data, combinational
- iRegWrite  in  1  main write enable
- iWriteRegister  in  ADDR_W  main write index
- iWriteData  in  DATA_W  main write data
- iAuxWrite  in  1  auxiliary write enable
- iAuxRegister  in  ADDR_W  auxiliary write index
- iAuxData  in  DATA_W  auxiliary write data
- oBusy  out  1  high while the clear sweep runs; writes ignored, reads masked

## Operation
- Two-state FSM: CLEAR, RUN. 5-bit-style sweep counter cnt, ADDR_W bits.
- iCLRn low: state=CLEAR, cnt=0, oBusy=1 immediately (async). Array contents not touched by reset.
- CLEAR, each edge: write array[cnt] = (cnt==SP_REG) ? SP_INIT : 0; cnt+1. On the edge writing index 2^ADDR_W-1: state=RUN, cnt wraps to 0.
- RUN: main write stores iWriteData at iWriteRegister when iRegWrite=1; auxiliary write stores iAuxData at iAuxRegister when iAuxWrite=1.
- Index 0 is hard zero: writes to it from either port are discarded in RUN; reads of index 0 always return 0.
- Same-index collision on both ports in one cycle: auxiliary data wins.
- Writes to SP_REG are ordinary writes; SP_INIT is only restored by a sweep.
- iSoftClr=1 at an edge (either state): state=CLEAR, cnt=0; any write presented that cycle is dropped; no sweep write occurs on that edge.
- Reads: while oBusy=1, oReadData1/2 and oRegDisp = 0. In RUN, they return array contents (see Configuration for same-cycle writes).

## Timing
- Reset values: oBusy=1; oReadData1, oReadData2, oRegDisp = 0.
- After iCLRn rises, sweep occupies 2^ADDR_W edges; oBusy falls after edge 2^ADDR_W (edge 32 with defaults). First accepted write at edge 2^ADDR_W+1.
- Soft clear asserted at edge k: oBusy high after edge k, low after edge k+2^ADDR_W.
- Write latency: data written at an edge is visible on read ports immediately after that edge (zero-cycle read-after-write in the next cycle).
- iCLRn low mid-sweep or mid-run: sweep restarts from 0 after release; partially swept contents are overwritten.

## Configuration
- REGFILE_BYPASS_EN defined: in RUN, a read port whose index matches an enabled write in the same cycle returns the write data combinationally (auxiliary over main; never for index 0). Not applied while oBusy=1.
- Undefined: read ports return the stored value; the new value appears after the edge.

## Test plan
- Reset release, wait: oBusy=1 for exactly 32 edges; then read index 29 -> 32764, indices 0,1,31 -> 0.
- RUN: main write 0xDEADBEEF to reg 8, read port1=8 next cycle -> 0xDEADBEEF; write 0x1234 to reg 0 -> reads 0.
- Main write reg 4 = 0x11, aux write reg 4 = 0x22 same edge -> reg 4 reads 0x22; aux to reg 2 alongside main to reg 3 -> both stored.
- Write reg 9 = 5 during oBusy (edge 10 after reset) -> after sweep reg 9 reads 0; iSoftClr in RUN after reg 29 = 0x100 -> oBusy 32 cycles, reg 29 back to 32764.
- With REGFILE_BYPASS_EN: read port2=7 while writing 0xAB to reg 7 -> oReadData2=0xAB same cycle; without macro -> old value, 0xAB next cycle.
- Assert iCLRn low at sweep edge 15 -> oBusy stays high, full 32-edge sweep after release, all registers correct.

Source files
------------

// File: rtl/regfile_bank_if.sv
// regfile_bank_if: bus bundle between the control/write-back path and the
// register bank.
//   master : drives read/display indices, main and auxiliary write requests,
//            soft-clear; receives read data, display data and busy.
//   slave  : the register bank side of the same signals.
interface regfile_bank_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              iSoftClr;
  logic [ADDR_W-1:0] iReadRegister1;
  logic [ADDR_W-1:0] iReadRegister2;
  logic [DATA_W-1:0] oReadData1;
  logic [DATA_W-1:0] oReadData2;
  logic [ADDR_W-1:0] iRegDispSelect;
  logic [DATA_W-1:0] oRegDisp;
  logic              iRegWrite;
  logic [ADDR_W-1:0] iWriteRegister;
  logic [DATA_W-1:0] iWriteData;
  logic              iAuxWrite;
  logic [ADDR_W-1:0] iAuxRegister;
  logic [DATA_W-1:0] iAuxData;
  logic              oBusy;

  modport master (
    output iSoftClr, iReadRegister1, iReadRegister2, iRegDispSelect,
           iRegWrite, iWriteRegister, iWriteData,
           iAuxWrite, iAuxRegister, iAuxData,
    input  oReadData1, oReadData2, oRegDisp, oBusy
  );

  modport slave (
    input  iSoftClr, iReadRegister1, iReadRegister2, iRegDispSelect,
           iRegWrite, iWriteRegister, iWriteData,
           iAuxWrite, iAuxRegister, iAuxData,
    output oReadData1, oReadData2, oRegDisp, oBusy
  );
endinterface

// File: rtl/regfile_bank.sv
// regfile_bank: parametrised general-purpose register bank.
//   Two combinational read ports plus a display port, a main write port and
//   an auxiliary write port that wins on same-index collisions. Contents are
//   initialised by a counter-driven sweep after reset or soft clear (index
//   SP_REG gets SP_INIT, everything else 0), so the array needs no per-bit
//   reset. Index 0 always reads 0.
// Ports:
//   iCLK   clock, rising edge
//   iCLRn  asynchronous active-low reset (restarts the sweep)
//   bus    regfile_bank_if.slave (read/display/write/aux/soft-clear/busy)
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to matching read ports (aux over main, never index 0, not while busy).
module regfile_bank #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned SP_REG  = 29,
  parameter logic [31:0] SP_INIT = 32'd32764
) (
  input  logic           iCLK,
  input  logic           iCLRn,
  regfile_bank_if.slave  bus
);

  localparam int unsigned NREG = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              sweep_we, main_we, aux_we, busy;
  logic [DATA_W-1:0] sweep_data;
  logic [DATA_W-1:0] mem [NREG];

  // Local copies of the bus inputs.
  logic              soft_clr, reg_write, aux_write;
  logic [ADDR_W-1:0] wr_idx, aux_idx, rd1_idx, rd2_idx, disp_idx;
  logic [DATA_W-1:0] wr_data, aux_data;

  assign soft_clr  = bus.iSoftClr;
  assign reg_write = bus.iRegWrite;
  assign aux_write = bus.iAuxWrite;
  assign wr_idx    = bus.iWriteRegister;
  assign aux_idx   = bus.iAuxRegister;
  assign rd1_idx   = bus.iReadRegister1;
  assign rd2_idx   = bus.iReadRegister2;
  assign disp_idx  = bus.iRegDispSelect;
  assign wr_data   = bus.iWriteData;
  assign aux_data  = bus.iAuxData;

  assign busy      = (state == CLEAR);
  assign bus.oBusy = busy;

  // State and sweep counter.
  always_ff @(posedge iCLK or negedge iCLRn) begin
    if (!iCLRn) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, sweep progress and qualified write enables.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sweep_we  = 1'b0;
    main_we   = 1'b0;
    aux_we    = 1'b0;
    if (soft_clr) begin
      state_nxt = CLEAR;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        CLEAR: begin
          // Held-in-reset edges must not disturb the array.
          sweep_we = iCLRn;
          cnt_nxt  = cnt + ADDR_W'(1);
          if (&cnt) state_nxt = RUN;
        end
        RUN: begin
          main_we = reg_write && (wr_idx != '0);
          aux_we  = aux_write && (aux_idx != '0);
        end
        default: ;
      endcase
    end
  end

  assign sweep_data = (cnt == ADDR_W'(SP_REG)) ? DATA_W'(SP_INIT) : '0;

  // Storage: no reset; later statements win, so aux overrides main.
  always_ff @(posedge iCLK) begin
    if (sweep_we) mem[cnt]     <= sweep_data;
    if (main_we)  mem[wr_idx]  <= wr_data;
    if (aux_we)   mem[aux_idx] <= aux_data;
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = mem[idx];
    if (busy || (idx == '0)) v = '0;
`ifdef REGFILE_BYPASS_EN
    else if (aux_we && (aux_idx == idx)) v = aux_data;
    else if (main_we && (wr_idx == idx)) v = wr_data;
`endif
    return v;
  endfunction

  // Combinational read ports.
  always_comb begin
    bus.oReadData1 = read_port(rd1_idx);
    bus.oReadData2 = read_port(rd2_idx);
    bus.oRegDisp   = read_port(disp_idx);
  end

endmodule

// File: tb/tb_regfile_bank.sv
// tb_regfile_bank: directed self-checking bench for regfile_bank.
// Expected read values are queued as each step is driven and compared when
// the read ports are sampled.
module tb_regfile_bank;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREG   = 32;

  logic iCLK  = 1'b0;
  logic iCLRn = 1'b1;

  always #50 iCLK = ~iCLK;

  regfile_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .SP_REG (29),
    .SP_INIT(32'd32764)
  ) dut (
    .iCLK (iCLK),
    .iCLRn(iCLRn),
    .bus  (bus)
  );

  typedef struct {
    string             tag;
    int                port;   // 0 = read1, 1 = read2, 2 = display
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input string tag, input int port,
                           input logic [ADDR_W-1:0] idx,
                           input logic [DATA_W-1:0] exp);
    sb_t e;
    e.tag  = tag;
    e.port = port;
    e.idx  = idx;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      sb_t e;
      logic [DATA_W-1:0] obs;
      e = sb.pop_front();
      case (e.port)
        0:       begin bus.iReadRegister1 = e.idx; #1; obs = bus.oReadData1; end
        1:       begin bus.iReadRegister2 = e.idx; #1; obs = bus.oReadData2; end
        default: begin bus.iRegDispSelect = e.idx; #1; obs = bus.oRegDisp;   end
      endcase
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle();
    bus.iSoftClr  = 1'b0;
    bus.iRegWrite = 1'b0;
    bus.iAuxWrite = 1'b0;
  endtask

  task automatic main_wr(input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] d);
    bus.iRegWrite      = 1'b1;
    bus.iWriteRegister = idx;
    bus.iWriteData     = d;
  endtask

  task automatic aux_wr(input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] d);
    bus.iAuxWrite    = 1'b1;
    bus.iAuxRegister = idx;
    bus.iAuxData     = d;
  endtask

  // Counts edges until oBusy falls (bounded) and checks the sweep length.
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (bus.oBusy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk(tag, DATA_W'(n), DATA_W'(NREG));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.iReadRegister1 = '0;
    bus.iReadRegister2 = '0;
    bus.iRegDispSelect = '0;
    bus.iWriteRegister = '0;
    bus.iWriteData     = '0;
    bus.iAuxRegister   = '0;
    bus.iAuxData       = '0;
    idle();

    // Asynchronous reset takes effect without a clock edge.
    #1 iCLRn = 1'b0;
    #2;
    chk("reset_busy", DATA_W'(bus.oBusy), 1);
    expect_rd("reset_rd1", 0, 5'd29, 0);
    expect_rd("reset_rd2", 1, 5'd3, 0);
    expect_rd("reset_disp", 2, 5'd31, 0);
    drain();
    repeat (2) tick();
    iCLRn = 1'b1;

    // Initial sweep; a write at edge 10 must be ignored.
    n = 0;
    while (bus.oBusy === 1'b1 && n < 100) begin
      tick();
      n++;
      if (n == 9) main_wr(5'd9, 32'd5);
      if (n == 10) idle();
      if (n == 31) begin
        bus.iReadRegister1 = 5'd29;
        #1;
        chk("busy_mask_rd1", bus.oReadData1, 0);
      end
    end
    chk("sweep_len_reset", DATA_W'(n), DATA_W'(NREG));

    expect_rd("sp_init", 0, 5'd29, 32'd32764);
    expect_rd("reg0_zero", 1, 5'd0, 0);
    expect_rd("reg1_zero", 2, 5'd1, 0);
    expect_rd("reg31_zero", 0, 5'd31, 0);
    expect_rd("busy_write_drop", 1, 5'd9, 0);
    drain();

    // Main write, read next cycle.
    main_wr(5'd8, 32'hDEADBEEF);
    tick();
    idle();
    expect_rd("main_wr8", 0, 5'd8, 32'hDEADBEEF);
    drain();

    // Index 0 is hard zero for both ports.
    main_wr(5'd0, 32'h1234);
    aux_wr(5'd0, 32'h99);
    tick();
    idle();
    expect_rd("reg0_rd1", 0, 5'd0, 0);
    expect_rd("reg0_disp", 2, 5'd0, 0);
    drain();

    // Same-index collision: aux wins.
    main_wr(5'd4, 32'h11);
    aux_wr(5'd4, 32'h22);
    tick();
    idle();
    expect_rd("collide4", 1, 5'd4, 32'h22);
    drain();

    // Distinct indices: both stored.
    aux_wr(5'd2, 32'hA2);
    main_wr(5'd3, 32'h33);
    tick();
    idle();
    expect_rd("aux_wr2", 0, 5'd2, 32'hA2);
    expect_rd("main_wr3", 1, 5'd3, 32'h33);
    expect_rd("disp8", 2, 5'd8, 32'hDEADBEEF);
    drain();

    // Same-cycle read of the register being written.
    bus.iReadRegister2 = 5'd7;
    bus.iReadRegister1 = 5'd6;
    main_wr(5'd7, 32'hAB);
    aux_wr(5'd6, 32'hC6);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_rd2", bus.oReadData2, 32'hAB);
    chk("same_cycle_rd1", bus.oReadData1, 32'hC6);
`else
    chk("same_cycle_rd2", bus.oReadData2, 0);
    chk("same_cycle_rd1", bus.oReadData1, 0);
`endif
    tick();
    idle();
    expect_rd("next_cycle_rd2", 1, 5'd7, 32'hAB);
    expect_rd("next_cycle_rd1", 0, 5'd6, 32'hC6);
    drain();

    // Stack pointer is an ordinary register in RUN.
    main_wr(5'd29, 32'h100);
    tick();
    idle();
    expect_rd("sp_write", 0, 5'd29, 32'h100);
    drain();

    // Soft clear with a concurrent write that must be dropped.
    bus.iSoftClr = 1'b1;
    main_wr(5'd5, 32'h55);
    tick();
    idle();
    chk("softclr_busy", DATA_W'(bus.oBusy), 1);
    expect_rd("softclr_mask", 0, 5'd8, 0);
    drain();
    count_busy("sweep_len_soft");
    expect_rd("soft_sp_restored", 0, 5'd29, 32'd32764);
    expect_rd("soft_drop5", 1, 5'd5, 0);
    expect_rd("soft_clr8", 2, 5'd8, 0);
    expect_rd("soft_clr4", 0, 5'd4, 0);
    drain();

    // Reset in the middle of a sweep restarts it in full.
    main_wr(5'd8, 32'h77);
    aux_wr(5'd31, 32'h31);
    tick();
    idle();
    expect_rd("pre_midreset8", 0, 5'd8, 32'h77);
    drain();
    bus.iSoftClr = 1'b1;
    tick();
    idle();
    repeat (15) tick();
    iCLRn = 1'b0;
    #1;
    chk("midreset_busy", DATA_W'(bus.oBusy), 1);
    bus.iReadRegister1 = 5'd8;
    #1;
    chk("midreset_mask", bus.oReadData1, 0);
    repeat (2) tick();
    iCLRn = 1'b1;
    count_busy("sweep_len_midreset");
    expect_rd("midreset_clr8", 0, 5'd8, 0);
    expect_rd("midreset_sp", 1, 5'd29, 32'd32764);
    expect_rd("midreset_clr31", 2, 5'd31, 0);
    expect_rd("midreset_clr6", 0, 5'd6, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
